// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_add_state_t;

endpackage

// File: rtl/serial_add_full_add.sv
// Single-bit full adder cell used by the serial datapath.
module serial_add_full_add (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum_c,
  output logic o_carry_c
);

  assign o_sum_c   = i_a ^ i_b ^ i_c;
  assign o_carry_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add.sv
// Bit-serial WIDTH-bit adder with ready/valid in and out, one bit per clock.
// Optional SERIAL_ADD_SUB_EN adds sub_i for a - b (sum_o[WIDTH]=1 means no borrow).
module serial_add
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   sum_o
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub_i
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned RES_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  serial_add_state_t r_state;
  serial_add_state_t w_state_nxt;
  logic              w_ready_nxt;
  logic              w_valid_nxt;
  logic              w_accept;
  logic              w_last;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [RES_W-1:0]  r_res;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_carry;

  logic              w_sub;
  logic              w_b_bit;
  logic              w_sum_bit;
  logic              w_carry_out;

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;

  // Operation select is latched with the operands.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= sub_i;
    end
  end

  assign w_sub = r_sub;
  logic w_carry_init;
  assign w_carry_init = sub_i;
`else
  assign w_sub = 1'b0;
  logic w_carry_init;
  assign w_carry_init = 1'b0;
`endif

  assign w_accept = (r_state == IDLE) && valid_i && ready_o;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_BIT);
  assign w_b_bit  = r_b[0] ^ w_sub;

  serial_add_full_add u_full_add (
    .i_a       (r_a[0]),
    .i_b       (w_b_bit),
    .i_c       (r_carry),
    .o_sum_c   (w_sum_bit),
    .o_carry_c (w_carry_out)
  );

  // State and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      ready_o <= w_ready_nxt;
      valid_o <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = 1'b0;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = DONE;
      DONE:    if (ready_i)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Outputs reflect the state being entered so they can be registered.
    case (w_state_nxt)
      IDLE:    w_ready_nxt = 1'b1;
      DONE:    w_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: operands shift right, sum bits enter the result at the top.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      sum_o   <= '0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_cnt   <= '0;
      r_carry <= w_carry_init;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= RES_W'({w_sum_bit, r_res} >> 1);
      r_cnt   <= r_cnt + CNT_W'(1);
      r_carry <= w_carry_out;
      if (w_last) begin
        sum_o <= {w_carry_out, w_sum_bit, r_res};
      end
    end
  end

endmodule
